// File: rtl/hazard_compositor.sv
// hazard_compositor: two-stage per-pixel compositor for Barry and NUM_OBS obstacles, with collision
// detection and the START/PLAY/OVER game FSM. Define HAZARD_SHIELD_EN to build the one-shot shield.
module hazard_compositor #(
  parameter int NUM_OBS       = 4,
  parameter int X_W           = 10,
  parameter int Y_W           = 9,
  parameter int HOLD_FRAMES   = 60,
  parameter int FLICK_SHIFT   = 3,
  parameter int SHIELD_FRAMES = 90
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   thrust,
  input  logic                   frame_start,
  input  logic                   pix_valid,
  input  logic [X_W-1:0]         x,
  input  logic [Y_W-1:0]         y,
  input  logic [X_W-1:0]         barry_x0,
  input  logic [X_W-1:0]         barry_x1,
  input  logic [Y_W-1:0]         barry_y0,
  input  logic [Y_W-1:0]         barry_y1,
  input  logic [NUM_OBS*X_W-1:0] obs_x,
  input  logic [NUM_OBS*2-1:0]   obs_type,
  input  logic [NUM_OBS*2-1:0]   obs_lane,
  input  logic [NUM_OBS-1:0]     obs_active,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   rgb_valid,
  output logic [1:0]             game_state,
  output logic                   game_over,
  output logic [NUM_OBS-1:0]     hit_mask
);
  localparam int XE     = X_W + 1;
  localparam int YE     = Y_W + 1;
  localparam int CW     = ((XE > YE) ? XE : YE) + 1;
  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_START = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  state_t state_reg, state_next;

  // One extra bit on every coordinate so x+100 and box edges never wrap.
  logic [XE-1:0] xe, xs, bx0, bx1;
  logic [YE-1:0] ye, by0, by1;
  assign xe  = {1'b0, x};
  assign xs  = xe + XE'(100);
  assign bx0 = {1'b0, barry_x0};
  assign bx1 = {1'b0, barry_x1};
  assign ye  = {1'b0, y};
  assign by0 = {1'b0, barry_y0};
  assign by1 = {1'b0, barry_y1};

  logic body_x, pack_x, head_y, torso_y, jet_y, fire_y;
  assign body_x  = (xe >= bx0 + XE'(10)) && (xe <= bx1);
  assign pack_x  = (xe >= bx0) && (xe <= bx0 + XE'(9));
  assign head_y  = (ye >= by0) && (ye <= by0 + YE'(14));
  assign torso_y = (ye >= by0 + YE'(15)) && (ye <= by1);
  assign jet_y   = (ye >= by0 + YE'(15)) && (ye <= by0 + YE'(44));
  assign fire_y  = (ye >= by0 + YE'(45)) && (ye <= by1);

  logic [NUM_OBS-1:0] obs_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBS; gi++) begin : g_obs
      logic [XE-1:0] ox, ow;
      logic [YE-1:0] oy0, oh;
      logic [CW-1:0] dx, dy;
      logic [1:0]    typ, lane;
      logic          in_x, in_y, in_shape;

      assign ox   = {1'b0, obs_x[gi*X_W +: X_W]};
      assign typ  = obs_type[gi*2 +: 2];
      assign lane = obs_lane[gi*2 +: 2];

      always_comb begin
        ow  = XE'(60);
        oh  = YE'(60);
        oy0 = YE'(0);
        case (typ)
          2'b00:   begin ow = XE'(100); oh = YE'(20);  end
          2'b01:   begin ow = XE'(20);  oh = YE'(100); end
          default: ;
        endcase
        case (lane)
          2'b01:   oy0 = YE'(140);
          2'b10:   oy0 = YE'(379);
          default: ;
        endcase
      end

      assign in_x = (xs >= ox) && (xs <= ox + ow - XE'(1));
      assign in_y = (ye >= oy0) && (ye <= oy0 + oh - YE'(1));
      // Offsets are only meaningful inside the bounding box; in_x/in_y gate them.
      assign dx   = CW'(xs) - CW'(ox);
      assign dy   = CW'(ye) - CW'(oy0);

      always_comb begin
        case (typ)
          2'b10:   in_shape = (dy <= dx);
          2'b11:   in_shape = (dx + dy >= CW'(oh - YE'(1)));
          default: in_shape = 1'b1;
        endcase
      end

      assign obs_hit[gi] = obs_active[gi] && (lane != 2'b11) && in_x && in_y && in_shape;
    end
  endgenerate

  logic               v1_reg, head_reg, torso_reg, jet_reg, fire_reg;
  logic [NUM_OBS-1:0] obs_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg    <= 1'b0;
      obs_reg   <= '0;
      head_reg  <= 1'b0;
      torso_reg <= 1'b0;
      jet_reg   <= 1'b0;
      fire_reg  <= 1'b0;
    end else begin
      v1_reg    <= pix_valid;
      obs_reg   <= obs_hit;
      head_reg  <= body_x && head_y;
      torso_reg <= body_x && torso_y;
      jet_reg   <= pack_x && jet_y;
      fire_reg  <= pack_x && fire_y && thrust;
    end
  end

  logic [7:0]         cnt_reg;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [NUM_OBS-1:0] hit_mask_reg, hit_mask_next;
  logic               start_q_reg, start_rise_reg;
  logic               collide, absorb, invuln;

  // start_q_reg keeps sampling during reset so a button held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    start_q_reg <= start;
    if (reset) start_rise_reg <= 1'b0;
    else       start_rise_reg <= start && !start_q_reg;
  end

  assign collide = v1_reg && (head_reg || torso_reg || jet_reg) && (|obs_reg)
                   && (state_reg == ST_PLAY);

`ifdef HAZARD_SHIELD_EN
  localparam int SH_W = $clog2(SHIELD_FRAMES + 1);
  logic            shield_reg;
  logic [SH_W-1:0] inv_reg;

  assign invuln = (inv_reg != '0);
  assign absorb = invuln || shield_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      shield_reg <= 1'b0;
      inv_reg    <= '0;
    end else if (state_reg == ST_START && start_rise_reg) begin
      shield_reg <= 1'b1;
      inv_reg    <= '0;
    end else if (collide && !invuln && shield_reg) begin
      shield_reg <= 1'b0;
      inv_reg    <= SH_W'(SHIELD_FRAMES);
    end else if (frame_start && invuln) begin
      inv_reg <= inv_reg - SH_W'(1);
    end
  end
`else
  // Without the shield every collision ends the game; SHIELD_FRAMES is unused here.
  assign invuln = 1'b0;
  assign absorb = (SHIELD_FRAMES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_START;
      hold_reg     <= '0;
      hit_mask_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      hit_mask_reg <= hit_mask_next;
      if (frame_start) cnt_reg <= cnt_reg + 8'd1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hit_mask_next = hit_mask_reg;
    hold_next     = '0;
    case (state_reg)
      ST_START: begin
        if (start_rise_reg) begin
          state_next    = ST_PLAY;
          hit_mask_next = '0;
        end
      end
      ST_PLAY: begin
        if (collide && !absorb) begin
          state_next    = ST_OVER;
          hit_mask_next = hit_mask_reg | obs_reg;
        end
      end
      ST_OVER: begin
        hold_next = hold_reg;
        if (frame_start && hold_reg < HOLD_W'(HOLD_FRAMES)) hold_next = hold_reg + HOLD_W'(1);
        if (start_rise_reg && hold_reg >= HOLD_W'(HOLD_FRAMES)) state_next = ST_START;
      end
      default: state_next = ST_START;
    endcase
  end

  logic [23:0] rgb_next, rgb_reg;
  logic        v2_reg;

  always_comb begin
    rgb_next = 24'h000000;
    if (v1_reg) begin
      case (state_reg)
        ST_PLAY: rgb_next = 24'hF0F0F0;
        ST_OVER: rgb_next = 24'h0000FF;
        default: rgb_next = 24'h00FF00;
      endcase
      if (state_reg == ST_PLAY) begin
        if (jet_reg)   rgb_next = 24'h141414;
        if (torso_reg) rgb_next = invuln ? 24'h00FFFF : 24'h0A0A80;
        if (head_reg)  rgb_next = 24'hA4674A;
        if (fire_reg)  rgb_next = 24'hFF8000;
      end
      // Walk downwards so the lowest-index obstacle is the one left standing.
      for (int i = NUM_OBS - 1; i >= 0; i--) begin
        if (obs_reg[i]) rgb_next = (cnt_reg[FLICK_SHIFT] ^ i[0]) ? 24'hFF8000 : 24'hFFFF00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg <= 24'h000000;
      v2_reg  <= 1'b0;
    end else begin
      rgb_reg <= rgb_next;
      v2_reg  <= v1_reg;
    end
  end

  assign r          = rgb_reg[23:16];
  assign g          = rgb_reg[15:8];
  assign b          = rgb_reg[7:0];
  assign rgb_valid  = v2_reg;
  assign game_state = state_reg;
  assign game_over  = (state_reg == ST_OVER);
  assign hit_mask   = hit_mask_reg;

endmodule

// File: tb/tb_hazard_compositor.sv
// Directed bench for hazard_compositor: reset, START screen, player regions, obstacle shapes,
// clipping, collisions, OVER hold and multi-channel hits. Covers HAZARD_SHIELD_EN when defined.
module tb_hazard_compositor;
  logic        clk = 1'b0;
  logic        reset, start, thrust, frame_start, pix_valid;
  logic [9:0]  x, barry_x0, barry_x1;
  logic [8:0]  y, barry_y0, barry_y1;
  logic [39:0] obs_x;
  logic [7:0]  obs_type, obs_lane;
  logic [3:0]  obs_active;
  logic [7:0]  r, g, b;
  logic        rgb_valid, game_over;
  logic [1:0]  game_state;
  logic [3:0]  hit_mask;
  logic [23:0] rgb;
  int checks = 0;
  int errors = 0;
  int fcnt   = 0;

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  hazard_compositor dut (
    .clk(clk), .reset(reset), .start(start), .thrust(thrust), .frame_start(frame_start),
    .pix_valid(pix_valid), .x(x), .y(y),
    .barry_x0(barry_x0), .barry_x1(barry_x1), .barry_y0(barry_y0), .barry_y1(barry_y1),
    .obs_x(obs_x), .obs_type(obs_type), .obs_lane(obs_lane), .obs_active(obs_active),
    .r(r), .g(g), .b(b), .rgb_valid(rgb_valid),
    .game_state(game_state), .game_over(game_over), .hit_mask(hit_mask)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel; on return r/g/b and game_state reflect it (2-cycle latency).
  task automatic show_pixel(input int px, input int py);
    x = 10'(px);
    y = 9'(py);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
    $display("pixel (%0d,%0d) -> rgb %06h state %0d hit_mask %04b", px, py, rgb, game_state, hit_mask);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      fcnt++;
    end
    $display("frames +%0d -> count %0d", n, fcnt);
  endtask

  task automatic press_start();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
    $display("start pulse -> state %0d", game_state);
  endtask

  task automatic set_obs(input int ch, input int ox, input logic [1:0] typ,
                         input logic [1:0] lane, input logic act);
    obs_x[ch*10 +: 10]   = 10'(ox);
    obs_type[ch*2 +: 2]  = typ;
    obs_lane[ch*2 +: 2]  = lane;
    obs_active[ch]       = act;
  endtask

  function automatic logic [23:0] obs_rgb(input int ch);
    return ((((fcnt >> 3) ^ ch) & 1) != 0) ? 24'hFF8000 : 24'hFFFF00;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; thrust = 1'b0; frame_start = 1'b0; pix_valid = 1'b1;
    x = 10'd500; y = 9'd400;
    barry_x0 = 10'd190; barry_x1 = 10'd220; barry_y0 = 9'd150; barry_y1 = 9'd200;
    obs_x = '0; obs_type = '0; obs_lane = '0; obs_active = '0;
    tick(); tick(); tick();
    checks++; if (game_state !== 2'b00) begin $display("FAIL reset_state: got %b want 00", game_state); errors++; end
    checks++; if (game_over !== 1'b0) begin $display("FAIL reset_over: got %b want 0", game_over); errors++; end
    checks++; if (hit_mask !== 4'b0000) begin $display("FAIL reset_mask: got %b want 0000", hit_mask); errors++; end
    checks++; if (rgb !== 24'h000000 || rgb_valid !== 1'b0) begin
      $display("FAIL reset_rgb: got %06h/%b want 000000/0", rgb, rgb_valid); errors++; end
    reset = 1'b0;
    tick();
    checks++; if (rgb_valid !== 1'b0) begin $display("FAIL valid_post1: got %b want 0", rgb_valid); errors++; end
    tick();
    checks++; if (rgb_valid !== 1'b1) begin $display("FAIL valid_post2: got %b want 1", rgb_valid); errors++; end
    checks++; if (rgb !== 24'h00FF00) begin $display("FAIL start_bg: got %06h want 00FF00", rgb); errors++; end
    tick(); tick();
    checks++; if (game_state !== 2'b00) begin $display("FAIL held_start: got %b want 00", game_state); errors++; end
    start = 1'b0; pix_valid = 1'b0;
    tick(); tick();
    $display("reset sequence done");
  endtask

  task automatic test_start_screen();
    set_obs(0, 300, 2'b00, 2'b00, 1'b1);   // x 200..299, y 0..19
    set_obs(1, 350, 2'b00, 2'b00, 1'b1);   // x 250..349, y 0..19
    show_pixel(220, 10);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL ch0_only: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(260, 10);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL priority: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(320, 10);
    checks++; if (rgb !== 24'hFF8000) begin $display("FAIL ch1_orange: got %06h want FF8000", rgb); errors++; end
    show_pixel(210, 180);
    checks++; if (rgb !== 24'h00FF00) begin $display("FAIL no_player_start: got %06h want 00FF00", rgb); errors++; end
    frames(8);
    show_pixel(320, 10);
    checks++; if (rgb !== 24'hFFFF00) begin $display("FAIL ch1_flicker: got %06h want FFFF00", rgb); errors++; end
    show_pixel(220, 10);
    checks++; if (rgb !== 24'hFF8000) begin $display("FAIL ch0_flicker: got %06h want FF8000", rgb); errors++; end
    set_obs(0, 300, 2'b00, 2'b11, 1'b1);
    show_pixel(220, 10);
    checks++; if (rgb !== 24'h00FF00) begin $display("FAIL lane_disabled: got %06h want 00FF00", rgb); errors++; end
    set_obs(1, 350, 2'b00, 2'b00, 1'b0);
    show_pixel(320, 10);
    checks++; if (rgb !== 24'h00FF00) begin $display("FAIL inactive: got %06h want 00FF00", rgb); errors++; end
    obs_active = '0;
  endtask

  task automatic test_start();
    start = 1'b1;
    tick();
    checks++; if (game_state !== 2'b00) begin $display("FAIL start_early: got %b want 00", game_state); errors++; end
    tick();
    checks++; if (game_state !== 2'b01) begin $display("FAIL start_play: got %b want 01", game_state); errors++; end
    start = 1'b0;
    tick();
  endtask

  task automatic test_player();
    show_pixel(210, 162);
    checks++; if (rgb !== 24'hA4674A) begin $display("FAIL head: got %06h want A4674A", rgb); errors++; end
    show_pixel(210, 180);
    checks++; if (rgb !== 24'h0A0A80) begin $display("FAIL torso: got %06h want 0A0A80", rgb); errors++; end
    show_pixel(192, 165);
    checks++; if (rgb !== 24'h141414) begin $display("FAIL jetpack: got %06h want 141414", rgb); errors++; end
    show_pixel(192, 164);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL jet_top_edge: got %06h want F0F0F0", rgb); errors++; end
    show_pixel(192, 197);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL fire_off: got %06h want F0F0F0", rgb); errors++; end
    thrust = 1'b1;
    show_pixel(192, 197);
    checks++; if (rgb !== 24'hFF8000) begin $display("FAIL fire_on: got %06h want FF8000", rgb); errors++; end
    thrust = 1'b0;
    show_pixel(500, 400);
    checks++; if (rgb !== 24'hF0F0F0 || game_state !== 2'b01) begin
      $display("FAIL play_bg: got %06h/%b want F0F0F0/01", rgb, game_state); errors++; end
  endtask

  task automatic test_triangle();
    set_obs(0, 160, 2'b10, 2'b00, 1'b1);   // falling, x 60..119, y 0..59
    show_pixel(70, 5);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL fall_in: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(60, 0);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL fall_corner: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(65, 50);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL fall_out: got %06h want F0F0F0", rgb); errors++; end
    show_pixel(120, 5);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL fall_right: got %06h want F0F0F0", rgb); errors++; end
    set_obs(0, 160, 2'b11, 2'b00, 1'b1);   // rising
    show_pixel(60, 59);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL rise_edge: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(60, 58);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL rise_out: got %06h want F0F0F0", rgb); errors++; end
  endtask

  task automatic test_clip();
    set_obs(0, 50, 2'b00, 2'b10, 1'b1);    // flat, x 0..49, y 379..398
    show_pixel(0, 380);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL clip_x0: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(9, 398);
    checks++; if (rgb !== obs_rgb(0)) begin $display("FAIL clip_x9: got %06h want %06h", rgb, obs_rgb(0)); errors++; end
    show_pixel(50, 380);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL clip_x50: got %06h want F0F0F0", rgb); errors++; end
    show_pixel(1020, 380);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL no_wrap: got %06h want F0F0F0", rgb); errors++; end
    show_pixel(5, 399);
    checks++; if (rgb !== 24'hF0F0F0) begin $display("FAIL clip_ybelow: got %06h want F0F0F0", rgb); errors++; end
    obs_active = '0;
  endtask

`ifdef HAZARD_SHIELD_EN
  task automatic test_shield();
    set_obs(2, 300, 2'b00, 2'b01, 1'b1);
    show_pixel(200, 155);
    checks++; if (game_state !== 2'b01 || hit_mask !== 4'b0000) begin
      $display("FAIL shield_absorb: got %b/%b want 01/0000", game_state, hit_mask); errors++; end
    show_pixel(210, 180);
    checks++; if (rgb !== 24'h00FFFF) begin $display("FAIL shield_torso: got %06h want 00FFFF", rgb); errors++; end
    frames(89);
    show_pixel(200, 155);
    checks++; if (game_state !== 2'b01) begin $display("FAIL shield_window: got %b want 01", game_state); errors++; end
    frames(1);
    show_pixel(210, 180);
    checks++; if (rgb !== 24'h0A0A80) begin $display("FAIL shield_expired: got %06h want 0A0A80", rgb); errors++; end
  endtask
`endif

  task automatic test_collision();
    obs_active = '0;
    set_obs(2, 300, 2'b00, 2'b01, 1'b1);   // x 200..299, y 140..159
    x = 10'd200; y = 9'd155; pix_valid = 1'b1;
    tick();
    checks++; if (game_state !== 2'b01) begin $display("FAIL hit_latency1: got %b want 01", game_state); errors++; end
    pix_valid = 1'b0;
    tick();
    checks++; if (game_over !== 1'b1 || game_state !== 2'b10) begin
      $display("FAIL hit_over: got %b/%b want 1/10", game_over, game_state); errors++; end
    checks++; if (hit_mask !== 4'b0100) begin $display("FAIL hit_mask: got %b want 0100", hit_mask); errors++; end
    checks++; if (rgb !== obs_rgb(2)) begin $display("FAIL hit_rgb: got %06h want %06h", rgb, obs_rgb(2)); errors++; end
    show_pixel(210, 180);
    checks++; if (rgb !== 24'h0000FF) begin $display("FAIL over_bg: got %06h want 0000FF", rgb); errors++; end
  endtask

  task automatic test_hold();
    frames(30);
    press_start();
    checks++; if (game_state !== 2'b10) begin $display("FAIL hold_30: got %b want 10", game_state); errors++; end
    frames(29);
    press_start();
    checks++; if (game_state !== 2'b10) begin $display("FAIL hold_59: got %b want 10", game_state); errors++; end
    frames(1);
    press_start();
    checks++; if (game_state !== 2'b00 || game_over !== 1'b0) begin
      $display("FAIL hold_60: got %b/%b want 00/0", game_state, game_over); errors++; end
    checks++; if (hit_mask !== 4'b0100) begin $display("FAIL mask_sticky: got %b want 0100", hit_mask); errors++; end
  endtask

  task automatic test_multi_hit();
    logic [23:0] want;
    press_start();
    checks++; if (game_state !== 2'b01 || hit_mask !== 4'b0000) begin
      $display("FAIL replay: got %b/%b want 01/0000", game_state, hit_mask); errors++; end
`ifdef HAZARD_SHIELD_EN
    show_pixel(200, 155);
    frames(90);
`endif
    set_obs(0, 300, 2'b00, 2'b01, 1'b1);
    want = obs_rgb(0);
    x = 10'd205; y = 9'd155; pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    fcnt++;
    checks++; if (game_state !== 2'b10 || hit_mask !== 4'b0101) begin
      $display("FAIL multi_hit: got %b/%b want 10/0101", game_state, hit_mask); errors++; end
    checks++; if (rgb !== want) begin $display("FAIL multi_rgb: got %06h want %06h", rgb, want); errors++; end
    frames(59);
    press_start();
    checks++; if (game_state !== 2'b10) begin $display("FAIL coincide_59: got %b want 10", game_state); errors++; end
    frames(1);
    press_start();
    checks++; if (game_state !== 2'b00) begin $display("FAIL coincide_60: got %b want 00", game_state); errors++; end
  endtask

  initial begin
    test_reset();
    test_start_screen();
    test_start();
    test_player();
    test_triangle();
    test_clip();
`ifdef HAZARD_SHIELD_EN
    test_shield();
`endif
    test_collision();
    test_hold();
    test_multi_hit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
